// File: rtl/mux_4to1_pkg.sv
// Select encodings for the 4:1 datapath selector, shared with control-unit decode.
package mux_4to1_pkg;

  localparam logic [1:0] SEL_I0 = 2'd0;
  localparam logic [1:0] SEL_I1 = 2'd1;
  localparam logic [1:0] SEL_I2 = 2'd2;
  localparam logic [1:0] SEL_I3 = 2'd3;

endpackage

// File: rtl/mux_4to1.sv
// 4:1 WIDTH-bit selector: dout is combinational with zero latency; dout_q is a one-cycle registered copy.
// No handshake and no backpressure: dout_q captures on en and holds otherwise, with synchronous reset taking priority.
module mux_4to1
  import mux_4to1_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic             en,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_q
);

  // An unknown select drives all-X so a bad control decode shows up in simulation.
  always_comb begin
    dout = 'x;
    case (select)
      SEL_I0:  dout = I0;
      SEL_I1:  dout = I1;
      SEL_I2:  dout = I2;
      SEL_I3:  dout = I3;
      default: dout = 'x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= RESET_VAL;
    end else if (en) begin
      dout_q <= dout;
    end
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Scoreboard bench for mux_4to1: checks the combinational path, the registered copy, and synchronous reset.
module tb_mux_4to1;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic [1:0]  select;
  logic [31:0] I0, I1, I2, I3;
  logic        en;
  logic [31:0] dout;
  logic [31:0] dout_q;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          n_cmp;
  int          n_bad;

  mux_4to1 #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .select (select),
    .I0     (I0),
    .I1     (I1),
    .I2     (I2),
    .I3     (I3),
    .en     (en),
    .dout   (dout),
    .dout_q (dout_q)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] a, b, c, d);
    case (s)
      2'd0:    pick = a;
      2'd1:    pick = b;
      2'd2:    pick = c;
      default: pick = d;
    endcase
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    en     = 1'b1;
    select = 2'd0;
    I0     = 32'hA5A5_A5A5;
    I1     = 32'h1;
    I2     = 32'h2;
    I3     = 32'h3;
    for (int e = 0; e < 2; e++) begin
      exp_q.push_back(32'h0);
      exp_q.push_back(32'hA5A5_A5A5);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (dout_q !== exp_v) begin
        n_bad++;
        $display("FAIL reset_dout_q edge%0d: got %h expected %h", e, dout_q, exp_v);
      end
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (dout !== exp_v) begin
        n_bad++;
        $display("FAIL reset_dout edge%0d: got %h expected %h", e, dout, exp_v);
      end
    end
  endtask

  task automatic test_enable_latency();
    @(negedge clk);
    rst_n  = 1'b1;
    en     = 1'b1;
    select = 2'd3;
    I3     = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dout_q !== exp_v) begin
      n_bad++;
      $display("FAIL enable_capture: got %h expected %h", dout_q, exp_v);
    end
    @(negedge clk);
    en = 1'b0;
    I3 = 32'h0;
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dout !== exp_v) begin
      n_bad++;
      $display("FAIL enable_dout_follows: got %h expected %h", dout, exp_v);
    end
    for (int e = 0; e < 2; e++) begin
      exp_q.push_back(32'h1234_5678);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (dout_q !== exp_v) begin
        n_bad++;
        $display("FAIL enable_hold edge%0d: got %h expected %h", e, dout_q, exp_v);
      end
    end
  endtask

  task automatic test_mid_cycle_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.push_back(32'h1234_5678);
    #2;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dout_q !== exp_v) begin
      n_bad++;
      $display("FAIL midreset_before_edge: got %h expected %h", dout_q, exp_v);
    end
    exp_q.push_back(32'h0);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dout_q !== exp_v) begin
      n_bad++;
      $display("FAIL midreset_after_edge: got %h expected %h", dout_q, exp_v);
    end
  endtask

  // Random select/data/enable per cycle; a small model tracks the register.
  task automatic test_back_to_back();
    logic [31:0] model_q;
    model_q = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      select = 2'($urandom_range(0, 3));
      I0     = $urandom;
      I1     = $urandom;
      I2     = $urandom;
      I3     = $urandom;
      en     = 1'($urandom_range(0, 1));
      if (en) model_q = pick(select, I0, I1, I2, I3);
      exp_q.push_back(model_q);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (dout_q !== exp_v) begin
        n_bad++;
        $display("FAIL b2b_dout_q iter%0d: got %h expected %h", i, dout_q, exp_v);
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_comb_sweep();
    clk_run = 1'b0;
    en      = 1'b0;
    I0      = 32'h0000_1111;
    I1      = 32'h2222_2222;
    I2      = 32'h3333_3333;
    I3      = 32'hFFFF_FFFF;
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      exp_q.push_back(pick(select, I0, I1, I2, I3));
      #10;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (dout !== exp_v) begin
        n_bad++;
        $display("FAIL sweep_sel%0d: got %h expected %h", s, dout, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 50; it++) begin
      I0 = $urandom;
      I1 = $urandom;
      I2 = $urandom;
      I3 = $urandom;
      for (int s = 0; s < 4; s++) begin
        select = 2'(s);
        exp_q.push_back(pick(select, I0, I1, I2, I3));
        #10;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (dout !== exp_v) begin
          n_bad++;
          $display("FAIL random it%0d sel%0d: got %h expected %h", it, s, dout, exp_v);
        end
      end
    end
  endtask

  task automatic test_input_change();
    select = 2'd2;
    I2     = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dout !== exp_v) begin
      n_bad++;
      $display("FAIL change_before: got %h expected %h", dout, exp_v);
    end
    I2 = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dout !== exp_v) begin
      n_bad++;
      $display("FAIL change_after: got %h expected %h", dout, exp_v);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    clk_run = 1'b1;
    rst_n   = 1'b1;
    en      = 1'b0;
    select  = 2'd0;
    I0      = '0;
    I1      = '0;
    I2      = '0;
    I3      = '0;

    test_reset();
    test_enable_latency();
    test_mid_cycle_reset();
    test_back_to_back();
    test_comb_sweep();
    test_random();
    test_input_change();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
